// File: rtl/crono_pkg.sv
// Shared definitions for the chronometer start/stop controller:
// FSM state encoding and the default RTC command codes.
package crono_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_START = 3'd1,
    RUN      = 3'd2,
    WR_STOP  = 3'd3,
    RING     = 3'd4
  } crono_state_e;

  localparam logic [2:0] DEF_CMD_START = 3'b101;
  localparam logic [2:0] DEF_CMD_STOP  = 3'b110;

endpackage

// File: rtl/crono_push_sync.sv
// Two-flop synchroniser for the push button followed by a rising-edge detector
// that only fires once a genuine low level has been observed after reset.
module crono_push_sync (
  input  logic clk,
  input  logic reset,
  input  logic push,
  output logic push_rise
);

  logic       sync1_r;
  logic       sync2_r;
  logic       prev_r;
  logic [1:0] seen_r;
  logic       armed_r;

  // Synchroniser, previous-sample flop and re-arm tracking.
  // seen_r marks when sync2_r carries a real sample instead of its reset value,
  // so a button held through reset release cannot look like a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      seen_r  <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      sync1_r <= push;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      seen_r  <= {seen_r[0], 1'b1};
      if (seen_r[1] && !sync2_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign push_rise = sync2_r & ~prev_r & armed_r;

endmodule

// File: rtl/crono_ctrl.sv
// Chronometer controller: issues start/stop write strobes to the RTC,
// raises the alarm when the countdown expires and optionally restarts it.
module crono_ctrl
  import crono_pkg::*;
#(
  parameter int unsigned      WR_CYCLES   = 257,
  parameter int unsigned      CMD_W       = 3,
  parameter int unsigned      DIR_W       = 8,
  parameter logic [CMD_W-1:0] CMD_START   = CMD_W'(DEF_CMD_START),
  parameter logic [CMD_W-1:0] CMD_STOP    = CMD_W'(DEF_CMD_STOP),
  parameter logic [DIR_W-1:0] CMD_ADDR    = {DIR_W{1'b0}},
  parameter int unsigned      RING_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             crono_end,
  input  logic             repeat_mode,
  output logic             WR_inistop,
  output logic [CMD_W-1:0] inistop,
  output logic [DIR_W-1:0] dir,
  output logic             ring,
  output logic             busy
);

  localparam int STR_W  = $clog2(WR_CYCLES + 1);
  localparam int RING_W = (RING_CYCLES > 0) ? $clog2(RING_CYCLES + 1) : 1;
  localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(WR_CYCLES - 32'd1);
  localparam logic [RING_W-1:0] RING_LAST =
    (RING_CYCLES > 0) ? RING_W'(RING_CYCLES - 32'd1) : {RING_W{1'b0}};

  crono_state_e      state_r;
  crono_state_e      state_nxt_s;
  logic              cancel_r;
  logic              cancel_nxt_s;
  logic [STR_W-1:0]  str_cnt_r;
  logic [RING_W-1:0] ring_cnt_r;
  logic              str_done_s;
  logic              ring_timeout_s;
  logic              push_rise_s;
  logic              wr_nxt_s;
  logic [CMD_W-1:0]  cmd_nxt_s;

  crono_push_sync u_push_sync (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rise (push_rise_s)
  );

  assign str_done_s     = (str_cnt_r == STR_LAST);
  assign ring_timeout_s = (RING_CYCLES != 32'd0) && (ring_cnt_r == RING_LAST);

  // Next-state and cancel-flag decision; presses during strobes fall through unused.
  always_comb begin
    state_nxt_s  = state_r;
    cancel_nxt_s = cancel_r;
    case (state_r)
      IDLE: begin
        if (push_rise_s) state_nxt_s = WR_START;
        else             state_nxt_s = IDLE;
      end
      WR_START: begin
        if (str_done_s) state_nxt_s = RUN;
        else            state_nxt_s = WR_START;
      end
      RUN: begin
        // Countdown expiry takes priority over a simultaneous cancel press.
        if (crono_end) begin
          state_nxt_s  = WR_STOP;
          cancel_nxt_s = 1'b0;
        end else if (push_rise_s) begin
          state_nxt_s  = WR_STOP;
          cancel_nxt_s = 1'b1;
        end else begin
          state_nxt_s  = RUN;
        end
      end
      WR_STOP: begin
        if (!str_done_s)   state_nxt_s = WR_STOP;
        else if (cancel_r) state_nxt_s = IDLE;
        else               state_nxt_s = RING;
      end
      RING: begin
        if (push_rise_s || ring_timeout_s) begin
          if (repeat_mode) state_nxt_s = WR_START;
          else             state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RING;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        cancel_nxt_s = 1'b0;
      end
    endcase
  end

  // Command code presented with the strobe of the state being entered.
  always_comb begin
    case (state_nxt_s)
      WR_START: cmd_nxt_s = CMD_START;
      WR_STOP:  cmd_nxt_s = CMD_STOP;
      default:  cmd_nxt_s = {CMD_W{1'b0}};
    endcase
  end

  assign wr_nxt_s = (state_nxt_s == WR_START) || (state_nxt_s == WR_STOP);

  // State, counters and registered outputs; counters restart on every state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cancel_r   <= 1'b0;
      str_cnt_r  <= {STR_W{1'b0}};
      ring_cnt_r <= {RING_W{1'b0}};
      WR_inistop <= 1'b0;
      inistop    <= {CMD_W{1'b0}};
      dir        <= {DIR_W{1'b0}};
      ring       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cancel_r <= cancel_nxt_s;
      if (state_nxt_s != state_r) begin
        str_cnt_r  <= {STR_W{1'b0}};
        ring_cnt_r <= {RING_W{1'b0}};
      end else begin
        if ((state_r == WR_START) || (state_r == WR_STOP)) str_cnt_r <= str_cnt_r + STR_W'(1'b1);
        else                                               str_cnt_r <= str_cnt_r;
        if ((state_r == RING) && (RING_CYCLES != 32'd0))   ring_cnt_r <= ring_cnt_r + RING_W'(1'b1);
        else                                               ring_cnt_r <= ring_cnt_r;
      end
      WR_inistop <= wr_nxt_s;
      inistop    <= cmd_nxt_s;
      dir        <= wr_nxt_s ? CMD_ADDR : {DIR_W{1'b0}};
      ring       <= (state_nxt_s == RING);
      busy       <= (state_nxt_s != IDLE);
    end
  end

endmodule

// File: doc/crono_ctrl.md
CRONO_CTRL -- requirements
Module: crono_ctrl

Interface
REQ-001 Parameter WR_CYCLES, default 257: write-strobe length in clk cycles, legal range 1..4095.
REQ-002 Parameter CMD_W, default 3: command bus width.
REQ-003 Parameter DIR_W, default 8: address bus width.
REQ-004 Parameter CMD_START, default 3'b101: start command code.
REQ-005 Parameter CMD_STOP, default 3'b110: stop command code.
REQ-006 Parameter CMD_ADDR, default 0: address driven during commands.
REQ-007 Parameter RING_CYCLES, default 0: alarm auto-silence length in cycles; 0 means ring until push.
REQ-008 clk  input  1  single system clock, rising-edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 push  input  1  debounced user button, asynchronous to clk.
REQ-011 crono_end  input  1  countdown-expired level from the timer datapath, synchronous to clk.
REQ-012 repeat_mode  input  1  when 1, acknowledging the alarm restarts the countdown.
REQ-013 WR_inistop  output  1  write strobe to the RTC interface.
REQ-014 inistop  output  CMD_W  command code, valid while WR_inistop=1, else 0.
REQ-015 dir  output  DIR_W  command address, CMD_ADDR while WR_inistop=1, else 0.
REQ-016 ring  output  1  alarm active.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 push SHALL pass a 2-flop synchroniser plus edge detector; only rising edges (push_rise) act.
REQ-019 FSM states SHALL be IDLE, WR_START, RUN, WR_STOP, RING; all outputs registered.
REQ-020 IDLE: push_rise -> WR_START; outputs change on the 3rd rising clk edge after push is first sampled high.
REQ-021 WR_START: WR_inistop=1, inistop=CMD_START, dir=CMD_ADDR for exactly WR_CYCLES cycles, then RUN.
REQ-022 RUN: crono_end=1 -> WR_STOP with cancel=0; push_rise -> WR_STOP with cancel=1.
REQ-023 RUN with crono_end and push_rise in the same cycle: crono_end wins (cancel=0).
REQ-024 WR_STOP: WR_inistop=1, inistop=CMD_STOP, dir=CMD_ADDR for exactly WR_CYCLES cycles; then RING if cancel=0, IDLE if cancel=1.
REQ-025 push_rise during WR_START or WR_STOP SHALL be ignored and not queued.
REQ-026 RING: ring=1; exit on push_rise, or after RING_CYCLES cycles when RING_CYCLES>0.
REQ-027 RING exit goes to WR_START if repeat_mode=1 in the exit cycle, else IDLE.
REQ-028 Push and timeout in the same cycle is a single exit.
REQ-029 The strobe counter SHALL be $clog2(WR_CYCLES+1) bits and clear on every state entry.
REQ-030 The ring counter SHALL be sized for RING_CYCLES and clear on RING entry.
REQ-031 WR_inistop SHALL drop to 0 for at least 1 cycle between consecutive commands.

Reset
REQ-032 reset=0 SHALL immediately force state IDLE, clear counters, synchroniser and cancel, and drive all outputs to 0.
REQ-033 Reset asserted mid-strobe SHALL abort the command; no partial resume after release.
REQ-034 After reset release, a push already held high SHALL NOT generate push_rise.

Structure
REQ-035 A shared package crono_pkg SHALL hold the state encoding and the default CMD_START/CMD_STOP codes.
REQ-036 One sub-module, crono_push_sync (synchroniser plus rising-edge detector), SHALL be instantiated.

Verification (WR_CYCLES=4, RING_CYCLES=0 unless stated)
REQ-037 Push pulse -> 3 edges later WR_inistop=1, inistop=101 for 4 cycles, then busy=1 with WR_inistop=0.
REQ-038 In RUN, crono_end=1 -> inistop=110 for 4 cycles, then ring=1; push -> ring=0, busy=0.
REQ-039 Push in RUN -> stop command for 4 cycles, ring never asserts, IDLE.
REQ-040 crono_end and push_rise in the same RUN cycle -> ring=1 after the stop command.
REQ-041 RING_CYCLES=10, repeat_mode=1 -> ring high for exactly 10 cycles, then a new 101 strobe.
REQ-042 reset=0 in cycle 2 of WR_START -> all outputs 0 without waiting for clk; with push held through release, IDLE holds.
